// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer for packed ALU result words,
// with a sticky error flag and saturating error/zero event counters.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_word,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          clr_status,
  output logic [LW-1:0] level,
  output logic          err_sticky,
  output logic [7:0]    err_count,
  output logic [7:0]    zero_count
);
  localparam int PW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_sticky_q, err_sticky_d;
  logic [7:0]    err_count_q, err_count_d, zero_count_q, zero_count_d;
  logic          push, pop, err_ev, zero_ev;
  // in_ready depends only on stored level, so a pop cannot free a full slot in the same cycle
  assign in_ready   = (level_q < LW'(DEPTH)) & ~rst;
  assign out_valid  = level_q != '0;
  assign out_word   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready & ~rst;
  assign err_ev     = push & in_word[4];
  assign zero_ev    = push & in_word[7];
  assign level      = level_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign zero_count = zero_count_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_word;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d      = (push & ~pop) ? level_q + LW'(1) : (~push & pop) ? level_q - LW'(1) : level_q;
    err_sticky_d = err_ev ? 1'b1 : clr_status ? 1'b0 : err_sticky_q;
    err_count_d  = err_ev ? (clr_status ? 8'd1 : (err_count_q == 8'hFF ? 8'hFF : err_count_q + 8'd1))
                 : clr_status ? 8'd0 : err_count_q;
    zero_count_d = zero_ev ? (clr_status ? 8'd1 : (zero_count_q == 8'hFF ? 8'hFF : zero_count_q + 8'd1))
                 : clr_status ? 8'd0 : zero_count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
      zero_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      zero_count_q <= zero_count_d;
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: scenario tasks plus randomized traffic against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DEPTH = 4;
  logic       clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr_status = 0;
  logic [7:0] in_word = 0;
  logic       in_ready, out_valid, err_sticky;
  logic [7:0] out_word, err_count, zero_count;
  logic [2:0] level;
  logic [29:0] dut_st;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  bit  m_sticky;
  int  m_err, m_zero;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH), .LW(3)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .clr_status(clr_status),
    .level(level), .err_sticky(err_sticky), .err_count(err_count), .zero_count(zero_count)
  );

  assign dut_st = {level, out_valid, out_word, in_ready, err_sticky, err_count, zero_count};

  function automatic logic [29:0] exp_st();
    logic [7:0] head;
    head = q.size() > 0 ? q[0] : 8'h00;
    return {3'(q.size()), q.size() > 0, head, (q.size() < DEPTH) && !rst, m_sticky, 8'(m_err), 8'(m_zero)};
  endfunction

  task automatic cycle(input logic v, input logic [7:0] w, input logic r, input logic c, input logic rs);
    bit push, pop;
    in_valid = v; in_word = w; out_ready = r; clr_status = c; rst = rs;
    push = v && !rs && q.size() < DEPTH;
    pop  = r && !rs && q.size() > 0;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_sticky = 0; m_err = 0; m_zero = 0;
    end else begin
      if (c) begin m_sticky = 0; m_err = 0; m_zero = 0; end
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(w);
        if (w[4]) begin m_sticky = 1; m_err = m_err < 255 ? m_err + 1 : 255; end
        if (w[7]) m_zero = m_zero < 255 ? m_zero + 1 : 255;
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0; clr_status = 0;
  endtask

  task automatic test_reset();
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst = 0; #1;
    checks++;
    if (dut_st !== {3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL reset_idle got %h exp %h", dut_st, {3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0});
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] words [4] = '{8'h03, 8'h1F, 8'h80, 8'h4A};
    foreach (words[i]) cycle(1, words[i], 0, 0, 0);
    checks++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got level %0d ready %b exp 4 0", level, in_ready);
    end
    cycle(1, 8'h55, 0, 0, 0);
    checks++;
    if (dut_st !== exp_st() || level !== 3'd4) begin errors++; $display("FAIL fill_reject got %h exp %h", dut_st, exp_st()); end
    foreach (words[i]) begin
      checks++;
      if (out_word !== words[i] || out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_order[%0d] got %h/%b exp %h/1", i, out_word, out_valid, words[i]);
      end
      cycle(0, 8'h00, 1, 0, 0);
    end
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00) begin
      errors++; $display("FAIL drain_empty got %b/%h exp 0/00", out_valid, out_word);
    end
  endtask

  task automatic test_streaming();
    cycle(1, 8'h20, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(8'h21 + i), 1, 0, 0);
      checks++;
      if (level !== 3'd1 || out_word !== 8'(8'h21 + i) || dut_st !== exp_st()) begin
        errors++; $display("FAIL stream[%0d] got level %0d word %h exp 1 %h", i, level, out_word, 8'(8'h21 + i));
      end
    end
    cycle(0, 8'h00, 1, 0, 0);
  endtask

  task automatic test_status();
    cycle(0, 8'h00, 0, 1, 0);
    cycle(1, 8'h90, 1, 0, 0);
    cycle(1, 8'h05, 1, 0, 0);
    checks++;
    if ({err_sticky, err_count, zero_count} !== {1'b1, 8'd1, 8'd1}) begin
      errors++; $display("FAIL status_events got %b %0d %0d exp 1 1 1", err_sticky, err_count, zero_count);
    end
    cycle(1, 8'h10, 1, 1, 0);
    checks++;
    if ({err_sticky, err_count, zero_count} !== {1'b1, 8'd1, 8'd0}) begin
      errors++; $display("FAIL status_clr_push got %b %0d %0d exp 1 1 0", err_sticky, err_count, zero_count);
    end
    cycle(0, 8'h00, 1, 1, 0);
    checks++;
    if ({err_sticky, err_count, zero_count, level} !== {1'b0, 8'd0, 8'd0, 3'd0}) begin
      errors++; $display("FAIL status_clr got %b %0d %0d lvl %0d exp 0 0 0 0", err_sticky, err_count, zero_count, level);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) cycle(1, 8'h80, 1, 0, 0);
    checks++;
    if (zero_count !== 8'd255 || err_count !== 8'd0) begin
      errors++; $display("FAIL saturation got zero %0d err %0d exp 255 0", zero_count, err_count);
    end
    cycle(0, 8'h00, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    cycle(1, 8'h10, 0, 0, 0);
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    checks++;
    if (level !== 3'd3 || err_count !== 8'd2) begin
      errors++; $display("FAIL pre_reset got level %0d err %0d exp 3 2", level, err_count);
    end
    cycle(1, 8'h33, 1, 0, 1);
    rst = 0; #1;
    checks++;
    if (dut_st !== {3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL reset_mid got %h exp %h", dut_st, {3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
      checks++;
      if (dut_st !== exp_st()) begin errors++; $display("FAIL random[%0d] got %h exp %h", i, dut_st, exp_st()); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_status();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
